rtc_controller: RTL and testbench



---
 rtl/rtc_controller_if.sv | 22 ++
 rtl/rtc_controller.sv | 141 ++++++++++++++
 tb/tb_rtc_controller.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_controller_if.sv
// Data-memory MMIO bus segment seen by the RTC block.
// Combinational read data, writes land on the next clock edge.
// No backpressure: every access completes in the cycle it is presented.
interface rtc_controller_if;
  logic [31:0] wAddress;
  logic        wReadEnable;
  logic        wWriteEnable;
  logic [31:0] wWriteData;
  wire  [31:0] wReadData;

  // Bus decoder / CPU side drives address, strobes and write data.
  modport master (
    output wAddress, wReadEnable, wWriteEnable, wWriteData,
    input  wReadData
  );

  // Peripheral side answers reads and accepts writes.
  modport slave (
    input  wAddress, wReadEnable, wWriteEnable, wWriteData,
    output wReadData
  );
endinterface

// File: rtl/rtc_controller.sv
// Millisecond RTC: prescaled tick, 32-bit TIME, CMP alarm, CTRL/status on MMIO; RTC_PERIODIC_EN adds PERIOD auto-reload.
// Latency: reads combinational, writes take effect at the edge, alarm_irq follows PEND/IE registers directly.
// Backpressure: none; the bus is never stalled and every access completes in its own cycle.
module rtc_controller #(
  parameter int          CLOCK_FREQ   = 50000000,
  parameter int          TICK_HZ      = 1000,
  parameter logic [31:0] BASE_ADDRESS = 32'hFF200500
) (
  input  logic              clock,
  input  logic              reset,
  rtc_controller_if.slave   bus,
  output logic [31:0]       miliseconds,
  output logic              alarm_irq
);

  localparam int DIVIDER = CLOCK_FREQ / TICK_HZ;
  localparam int PW      = $clog2(DIVIDER);
  localparam logic [PW-1:0] PS_LAST = PW'(DIVIDER - 1);

  localparam logic [31:0] ADDR_TIME   = BASE_ADDRESS;
  localparam logic [31:0] ADDR_CMP    = BASE_ADDRESS + 32'd4;
  localparam logic [31:0] ADDR_CTRL   = BASE_ADDRESS + 32'd8;
`ifdef RTC_PERIODIC_EN
  localparam logic [31:0] ADDR_PERIOD = BASE_ADDRESS + 32'd12;
`endif

  logic [PW-1:0] ps_q;
  logic [31:0]   time_q;
  logic [31:0]   cmp_q;
  logic          en_q;
  logic          ie_q;
  logic          pend_q;
`ifdef RTC_PERIODIC_EN
  logic [31:0]   period_q;
`endif

  logic          wr_time;
  logic          wr_cmp;
  logic          wr_ctrl;
  logic          tick;
  logic [31:0]   time_inc;
  logic          match;
  logic          sel;
  logic [31:0]   rd_dat;

  assign wr_time  = bus.wWriteEnable && (bus.wAddress == ADDR_TIME);
  assign wr_cmp   = bus.wWriteEnable && (bus.wAddress == ADDR_CMP);
  assign wr_ctrl  = bus.wWriteEnable && (bus.wAddress == ADDR_CTRL);

  assign tick     = en_q && (ps_q == PS_LAST);
  assign time_inc = time_q + 32'd1;
  // A TIME write overrides the tick, so the suppressed increment cannot raise an alarm.
  assign match    = tick && !wr_time && (time_inc == cmp_q);

  // Prescaler and millisecond counter; a software TIME write restarts the millisecond.
  always_ff @(posedge clock) begin
    if (reset) begin
      ps_q   <= '0;
      time_q <= '0;
    end else if (wr_time) begin
      ps_q   <= '0;
      time_q <= bus.wWriteData;
    end else if (tick) begin
      ps_q   <= '0;
      time_q <= time_inc;
    end else if (en_q) begin
      ps_q   <= ps_q + PW'(1);
    end
  end

  // Compare register; match check above always sees the pre-write value.
  always_ff @(posedge clock) begin
    if (reset) begin
      cmp_q <= 32'hFFFF_FFFF;
    end else if (wr_cmp) begin
      cmp_q <= bus.wWriteData;
`ifdef RTC_PERIODIC_EN
    end else if (match && (period_q != 32'd0)) begin
      cmp_q <= cmp_q + period_q;
`endif
    end
  end

`ifdef RTC_PERIODIC_EN
  // Reload interval for periodic alarms; zero keeps the alarm one-shot.
  always_ff @(posedge clock) begin
    if (reset) begin
      period_q <= '0;
    end else if (bus.wWriteEnable && (bus.wAddress == ADDR_PERIOD)) begin
      period_q <= bus.wWriteData;
    end
  end
`endif

  // Control bits and pending flag; a new match beats a same-cycle write-1-to-clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      en_q   <= 1'b1;
      ie_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en_q <= bus.wWriteData[0];
        ie_q <= bus.wWriteData[1];
      end
      if (match) begin
        pend_q <= 1'b1;
      end else if (wr_ctrl && bus.wWriteData[2]) begin
        pend_q <= 1'b0;
      end
    end
  end

  // Register select and read mux; exact address match only.
  always_comb begin
    sel    = 1'b0;
    rd_dat = '0;
    if (bus.wAddress == ADDR_TIME) begin
      sel    = 1'b1;
      rd_dat = time_q;
    end else if (bus.wAddress == ADDR_CMP) begin
      sel    = 1'b1;
      rd_dat = cmp_q;
    end else if (bus.wAddress == ADDR_CTRL) begin
      sel    = 1'b1;
      rd_dat = {29'd0, pend_q, ie_q, en_q};
`ifdef RTC_PERIODIC_EN
    end else if (bus.wAddress == ADDR_PERIOD) begin
      sel    = 1'b1;
      rd_dat = period_q;
`endif
    end
  end

  // Release the shared bus when not addressed; drive zero when addressed without a read.
  assign bus.wReadData = !sel ? {32{1'bz}} : (bus.wReadEnable ? rd_dat : 32'd0);

  assign miliseconds = time_q;
  assign alarm_irq   = pend_q && ie_q;

endmodule

// File: tb/tb_rtc_controller.sv
// Self-checking bench for rtc_controller with DIVIDER = 10.
// Expected values are queued when stimulus is applied and popped when the DUT is sampled.
// All sampling happens 1-2 ns after a rising edge, never on it.
module tb_rtc_controller;

  localparam logic [31:0] BASE = 32'hFF200500;

  logic        clock;
  logic        reset;
  logic [31:0] miliseconds;
  logic        alarm_irq;

  rtc_controller_if bus ();

  rtc_controller #(
    .CLOCK_FREQ   (10),
    .TICK_HZ      (1),
    .BASE_ADDRESS (BASE)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.slave),
    .miliseconds (miliseconds),
    .alarm_irq   (alarm_irq)
  );

  int          checks;
  int          passes;
  logic [31:0] exp_q[$];
  logic [31:0] obs;
  logic [31:0] exp;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance n rising edges and park 1 ns after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One-cycle write; consumes exactly one rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.wAddress     = a;
    bus.wWriteData   = d;
    bus.wWriteEnable = 1'b1;
    @(posedge clock);
    #1;
    bus.wWriteEnable = 1'b0;
    bus.wAddress     = 32'd0;
  endtask

  // Combinational read between edges; consumes no edge.
  task automatic bus_read(input logic [31:0] a, input logic re, output logic [31:0] v);
    bus.wAddress    = a;
    bus.wReadEnable = re;
    #1;
    v = bus.wReadData;
    bus.wReadEnable = 1'b0;
    bus.wAddress    = 32'd0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    obs = miliseconds; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL reset_ms: got %h want %h", obs, exp); else passes++;
    obs = {31'd0, alarm_irq}; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL reset_irq: got %h want %h", obs, exp); else passes++;
    exp_q.push_back(32'd0);
    cyc(9);
    obs = miliseconds; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL tick_9cyc: got %h want %h", obs, exp); else passes++;
    exp_q.push_back(32'd1);
    cyc(1);
    obs = miliseconds; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL tick_10cyc: got %h want %h", obs, exp); else passes++;
    exp_q.push_back(32'd2);
    cyc(15);
    obs = miliseconds; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL tick_25cyc: got %h want %h", obs, exp); else passes++;
    exp_q.push_back(32'h1);
    exp_q.push_back(32'hFFFF_FFFF);
    bus_read(BASE + 8, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL reset_ctrl: got %h want %h", obs, exp); else passes++;
    bus_read(BASE + 4, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL reset_cmp: got %h want %h", obs, exp); else passes++;
  endtask

  task automatic test_alarm;
    bus_write(BASE + 4, 32'd3);
    bus_write(BASE + 8, 32'd3);
    bus_write(BASE, 32'd0);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'h3);
    cyc(29);
    obs = miliseconds; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL alarm_pre_ms: got %h want %h", obs, exp); else passes++;
    obs = {31'd0, alarm_irq}; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL alarm_pre_irq: got %h want %h", obs, exp); else passes++;
    bus_read(BASE + 8, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL alarm_pre_ctrl: got %h want %h", obs, exp); else passes++;
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h7);
    cyc(1);
    obs = miliseconds; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL alarm_ms: got %h want %h", obs, exp); else passes++;
    obs = {31'd0, alarm_irq}; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL alarm_irq: got %h want %h", obs, exp); else passes++;
    bus_read(BASE + 8, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL alarm_ctrl_pend: got %h want %h", obs, exp); else passes++;
    exp_q.push_back(32'h3);
    exp_q.push_back(32'd0);
    bus_write(BASE + 8, 32'h7);
    bus_read(BASE + 8, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL alarm_clear_ctrl: got %h want %h", obs, exp); else passes++;
    obs = {31'd0, alarm_irq}; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL alarm_clear_irq: got %h want %h", obs, exp); else passes++;
  endtask

  task automatic test_write_priority;
    bus_write(BASE, 32'd5);
    cyc(9);
    exp_q.push_back(32'hFFFF_FFFF);
    bus_write(BASE, 32'hFFFF_FFFF);
    obs = miliseconds; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL wr_vs_tick: got %h want %h", obs, exp); else passes++;
    exp_q.push_back(32'hFFFF_FFFF);
    cyc(9);
    obs = miliseconds; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL ps_restart: got %h want %h", obs, exp); else passes++;
    exp_q.push_back(32'd0);
    cyc(1);
    obs = miliseconds; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL time_wrap: got %h want %h", obs, exp); else passes++;
    // CMP written on the tick that reaches the new value: old CMP governs the match.
    bus_write(BASE, 32'd10);
    cyc(9);
    exp_q.push_back(32'd11);
    exp_q.push_back(32'h3);
    exp_q.push_back(32'd11);
    bus_write(BASE + 4, 32'd11);
    obs = miliseconds; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL cmp_race_ms: got %h want %h", obs, exp); else passes++;
    bus_read(BASE + 8, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL cmp_race_ctrl: got %h want %h", obs, exp); else passes++;
    bus_read(BASE + 4, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL cmp_race_cmp: got %h want %h", obs, exp); else passes++;
    exp_q.push_back(32'h3);
    exp_q.push_back(32'd0);
    bus_write(BASE, 32'd11);
    bus_read(BASE + 8, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL sw_time_eq_cmp_ctrl: got %h want %h", obs, exp); else passes++;
    obs = {31'd0, alarm_irq}; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL sw_time_eq_cmp_irq: got %h want %h", obs, exp); else passes++;
  endtask

  task automatic test_clear_set_race;
    bus_write(BASE + 4, 32'd3);
    bus_write(BASE, 32'd2);
    cyc(9);
    exp_q.push_back(32'h7);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd3);
    bus_write(BASE + 8, 32'h7);
    bus_read(BASE + 8, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL race_ctrl: got %h want %h", obs, exp); else passes++;
    obs = {31'd0, alarm_irq}; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL race_irq: got %h want %h", obs, exp); else passes++;
    obs = miliseconds; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL race_ms: got %h want %h", obs, exp); else passes++;
    exp_q.push_back(32'h3);
    bus_write(BASE + 8, 32'h7);
    bus_read(BASE + 8, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL race_clear: got %h want %h", obs, exp); else passes++;
  endtask

  task automatic test_bus_isolation;
    bus_write(BASE + 8, 32'h2);
    bus_write(BASE, 32'd100);
    exp_q.push_back(32'hzzzz_zzzz);
    exp_q.push_back(32'hzzzz_zzzz);
    bus_read(BASE + 16, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL iso_rd_base16: got %h want %h", obs, exp); else passes++;
    bus_read(BASE + 1, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL iso_rd_base1: got %h want %h", obs, exp); else passes++;
`ifndef RTC_PERIODIC_EN
    exp_q.push_back(32'hzzzz_zzzz);
    bus_read(BASE + 12, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL iso_rd_base12: got %h want %h", obs, exp); else passes++;
    bus_write(BASE + 12, 32'd55);
`endif
    bus_write(BASE + 1, 32'd55);
    bus_write(BASE + 16, 32'd55);
    bus_write(BASE + 9, 32'h7);
    exp_q.push_back(32'd100);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'h2);
    exp_q.push_back(32'd0);
    bus_read(BASE, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL iso_time: got %h want %h", obs, exp); else passes++;
    bus_read(BASE + 4, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL iso_cmp: got %h want %h", obs, exp); else passes++;
    bus_read(BASE + 8, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL iso_ctrl: got %h want %h", obs, exp); else passes++;
    bus_read(BASE, 1'b0, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL sel_no_rd: got %h want %h", obs, exp); else passes++;
    exp_q.push_back(32'd100);
    cyc(50);
    obs = miliseconds; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL en0_freeze: got %h want %h", obs, exp); else passes++;
    bus_write(BASE + 8, 32'h3);
  endtask

`ifdef RTC_PERIODIC_EN
  task automatic test_periodic;
    bus_write(BASE + 12, 32'd4);
    bus_write(BASE + 4, 32'd2);
    bus_write(BASE, 32'd0);
    exp_q.push_back(32'h3);
    cyc(19);
    bus_read(BASE + 8, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL per_pre_ctrl: got %h want %h", obs, exp); else passes++;
    exp_q.push_back(32'd2);
    exp_q.push_back(32'h7);
    exp_q.push_back(32'd6);
    cyc(1);
    obs = miliseconds; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL per1_ms: got %h want %h", obs, exp); else passes++;
    bus_read(BASE + 8, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL per1_ctrl: got %h want %h", obs, exp); else passes++;
    bus_read(BASE + 4, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL per1_cmp: got %h want %h", obs, exp); else passes++;
    bus_write(BASE + 8, 32'h7);
    exp_q.push_back(32'h3);
    cyc(38);
    bus_read(BASE + 8, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL per2_pre_ctrl: got %h want %h", obs, exp); else passes++;
    exp_q.push_back(32'd6);
    exp_q.push_back(32'h7);
    exp_q.push_back(32'd10);
    exp_q.push_back(32'd4);
    cyc(1);
    obs = miliseconds; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL per2_ms: got %h want %h", obs, exp); else passes++;
    bus_read(BASE + 8, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL per2_ctrl: got %h want %h", obs, exp); else passes++;
    bus_read(BASE + 4, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL per2_cmp: got %h want %h", obs, exp); else passes++;
    bus_read(BASE + 12, 1'b1, obs); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) $display("FAIL per_period: got %h want %h", obs, exp); else passes++;
  endtask
`endif

  initial begin
    checks = 0;
    passes = 0;
    reset            = 1'b1;
    bus.wAddress     = 32'd0;
    bus.wReadEnable  = 1'b0;
    bus.wWriteEnable = 1'b0;
    bus.wWriteData   = 32'd0;
    test_reset;
    test_alarm;
    test_write_priority;
    test_clear_set_race;
    test_bus_isolation;
`ifdef RTC_PERIODIC_EN
    test_periodic;
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
